// File: rtl/cla_pkg.sv
// Shared types for the nibble-serial CLA sequencer.
// Holds the FSM state encoding and the slice width.
package cla_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_wide_sequencer_if.sv
// Request/result bundle between operand source and sequencer.
// The sequencer side uses the slave modport.
interface cla_wide_sequencer_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output start, A, B, Cin,
    input  ready, busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, A, B, Cin,
    output ready, busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/cla_nibble_slice.sv
// Combinational 4-bit carry-lookahead slice.
// Exposes c3 so the caller can derive signed overflow.
module cla_nibble_slice
  import cla_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                c3,
  output logic                co
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;

  assign g = a & b;
  assign p = a ^ b;

  assign c1 = g[0] | (p[0] & ci);
  assign c2 = g[1] | (p[1] & g[0])
            | (p[1] & p[0] & ci);
  assign c3 = g[2] | (p[2] & g[1])
            | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & ci);
  assign co = g[3] | (p[3] & g[2])
            | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/cla_wide_sequencer.sv
// Nibble-serial wide adder: one CLA slice reused per clock,
// LSB nibble first, carry chained through a register.
module cla_wide_sequencer
  import cla_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input logic clk,
  input logic rst_n,
  cla_wide_sequencer_if.slave bus
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t              state;
  logic [IW-1:0]       idx;
  logic [IW:0]         nxt;
  logic                carry;
  logic                primed;
  logic                last;
  logic [W-1:0]        opa;
  logic [W-1:0]        opb;
  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [NIBBLE_W-1:0] s;
  logic                c3;
  logic                co;

  assign nxt  = {1'b0, idx} + 1'b1;
  assign last = (idx == IW'(NIBBLES - 1));

  // Slice operands come from registers, keeping the
  // wide nibble mux out of the carry-lookahead path.
  cla_nibble_slice u_slice (
    .a  (a_nib),
    .b  (b_nib),
    .ci (carry),
    .s  (s),
    .c3 (c3),
    .co (co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bus.ready <= 1'b1;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
      bus.ovf  <= 1'b0;
      idx      <= '0;
      carry    <= 1'b0;
      primed   <= 1'b0;
      opa      <= '0;
      opb      <= '0;
      a_nib    <= '0;
      b_nib    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            opa      <= bus.A;
            opb      <= bus.B;
            carry    <= bus.Cin;
            idx      <= '0;
            primed   <= 1'b0;
            bus.sum  <= '0;
            bus.cout <= 1'b0;
            bus.ovf  <= 1'b0;
            bus.ready <= 1'b0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (!primed) begin
            a_nib  <= opa[NIBBLE_W-1:0];
            b_nib  <= opb[NIBBLE_W-1:0];
            primed <= 1'b1;
          end else begin
            bus.sum[idx*NIBBLE_W +: NIBBLE_W] <= s;
            carry <= co;
            if (last) begin
              bus.cout <= co;
              bus.ovf  <= c3 ^ co;
              bus.done <= 1'b1;
              state    <= DONE;
            end else begin
              idx   <= idx + 1'b1;
              a_nib <= opa[nxt*NIBBLE_W +: NIBBLE_W];
              b_nib <= opb[nxt*NIBBLE_W +: NIBBLE_W];
            end
          end
        end
        DONE: begin
          bus.done  <= 1'b0;
          bus.busy  <= 1'b0;
          bus.ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_wide_sequencer.sv
// Self-checking bench for cla_wide_sequencer (NIBBLES=4 and 1).
// Vectors, hand sequences and random ops against a sum model.
module tb_cla_wide_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cla_wide_sequencer_if #(.NIBBLES(4)) if4 ();
  cla_wide_sequencer_if #(.NIBBLES(1)) if1 ();

  cla_wide_sequencer #(.NIBBLES(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4.slave)
  );

  cla_wide_sequencer #(.NIBBLES(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: plain W-bit two's-complement addition.
  task automatic model(input int w,
                       input logic [15:0] a, b,
                       input logic cin,
                       output logic [15:0] s,
                       output logic co, ov);
    logic [16:0] full;
    logic [15:0] mask;
    logic        sa, sb, ss;
    mask = 16'((17'd1 << w) - 17'd1);
    full = 17'(a & mask) + 17'(b & mask) + 17'(cin);
    s    = full[15:0] & mask;
    co   = full[w];
    sa   = a[w-1];
    sb   = b[w-1];
    ss   = s[w-1];
    ov   = (sa == sb) && (ss != sa);
  endtask

  task automatic op4(input logic [15:0] a, b,
                     input logic cin,
                     output logic [15:0] s,
                     output logic co, ov,
                     output int lat);
    @(negedge clk);
    check("ready_before_start", 32'(if4.ready), 32'd1);
    if4.start = 1'b1;
    if4.A = a;
    if4.B = b;
    if4.Cin = cin;
    @(posedge clk);
    #1;
    if4.start = 1'b0;
    if4.A = 16'($urandom);
    if4.B = 16'($urandom);
    if4.Cin = 1'($urandom);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (if4.done) break;
    end
    if (!if4.done) lat = 99;
    s  = if4.sum;
    co = if4.cout;
    ov = if4.ovf;
  endtask

  initial begin
    logic [15:0] s, es;
    logic        co, ov, eco, eov;
    int          lat;
    logic        saw_done;

    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1};

    if4.start = 1'b0; if4.A = '0; if4.B = '0; if4.Cin = 1'b0;
    if1.start = 1'b0; if1.A = '0; if1.B = '0; if1.Cin = 1'b0;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(if4.ready), 32'd1);
    check("rst_busy", 32'(if4.busy), 32'd0);
    check("rst_done", 32'(if4.done), 32'd0);
    check("rst_sum", 32'(if4.sum), 32'd0);
    check("rst_cout_ovf", 32'({if4.cout, if4.ovf}), 32'd0);
    check("rst1_ready", 32'(if1.ready), 32'd1);

    for (int i = 0; i < 4; i++) begin
      op4(vecs[i].a, vecs[i].b, vecs[i].cin, s, co, ov, lat);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'd5);
      check($sformatf("vec%0d_sum", i), 32'(s), 32'(vecs[i].sum));
      check($sformatf("vec%0d_cout", i), 32'(co), 32'(vecs[i].cout));
      check($sformatf("vec%0d_ovf", i), 32'(ov), 32'(vecs[i].ovf));
      check($sformatf("vec%0d_busy_done", i), 32'({if4.busy, if4.ready}), 32'b10);
      @(negedge clk);
      check($sformatf("vec%0d_pulse", i), 32'({if4.done, if4.ready}), 32'b01);
    end

    // start during RUN and during DONE must be ignored
    @(negedge clk);
    if4.start = 1'b1; if4.A = 16'h0005; if4.B = 16'h0003; if4.Cin = 1'b0;
    @(posedge clk);
    #1;
    if4.start = 1'b0; if4.A = 16'hAAAA;
    @(negedge clk);
    if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    lat = 0;
    while (!if4.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("ign_done_seen", 32'(if4.done), 32'd1);
    check("ign_sum", 32'(if4.sum), 32'h0008);
    if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    check("ign_not_accepted", 32'({if4.busy, if4.ready}), 32'b01);
    check("ign_sum_held", 32'(if4.sum), 32'h0008);
    op4(16'h1111, 16'h2222, 1'b0, s, co, ov, lat);
    check("after_ign_sum", 32'(s), 32'h3333);

    // reset on the second RUN cycle
    @(negedge clk);
    if4.start = 1'b1; if4.A = 16'hF0F0; if4.B = 16'h0F0F; if4.Cin = 1'b1;
    @(posedge clk);
    #1;
    if4.start = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready_busy", 32'({if4.ready, if4.busy}), 32'b10);
    check("mid_rst_outs", 32'({if4.done, if4.cout, if4.ovf, if4.sum}), 32'd0);
    saw_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (if4.done) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (if4.done) saw_done = 1'b1;
    end
    check("mid_rst_no_done", 32'(saw_done), 32'd0);
    op4(16'h00FF, 16'h0001, 1'b1, s, co, ov, lat);
    check("post_rst_sum", 32'(s), 32'h0101);
    check("post_rst_cout", 32'(co), 32'd0);

    for (int i = 0; i < 30; i++) begin
      logic [15:0] ra, rb;
      logic        rc;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      if (i == 0) begin ra = 16'h0000; rb = 16'h0000; rc = 1'b0; end
      if (i == 1) begin ra = 16'hFFFF; rb = 16'hFFFF; rc = 1'b1; end
      model(16, ra, rb, rc, es, eco, eov);
      op4(ra, rb, rc, s, co, ov, lat);
      check($sformatf("rnd%0d_lat", i), 32'(lat), 32'd5);
      check($sformatf("rnd%0d_res", i), 32'({ov, co, s}), 32'({eov, eco, es}));
    end

    // single-nibble build
    for (int i = 0; i < 8; i++) begin
      logic [3:0] ra, rb;
      logic       rc;
      int         l1;
      ra = 4'($urandom);
      rb = 4'($urandom);
      rc = 1'($urandom);
      if (i == 0) begin ra = 4'hF; rb = 4'h1; rc = 1'b1; end
      model(4, 16'(ra), 16'(rb), rc, es, eco, eov);
      @(negedge clk);
      if1.start = 1'b1; if1.A = ra; if1.B = rb; if1.Cin = rc;
      @(posedge clk);
      #1;
      if1.start = 1'b0; if1.A = 4'($urandom); if1.B = 4'($urandom);
      l1 = 0;
      while (l1 < 20) begin
        @(posedge clk);
        l1++;
        @(negedge clk);
        if (if1.done) break;
      end
      if (!if1.done) l1 = 99;
      check($sformatf("n1_%0d_lat", i), 32'(l1), 32'd2);
      check($sformatf("n1_%0d_res", i), 32'({if1.ovf, if1.cout, if1.sum}),
            32'({eov, eco, es[3:0]}));
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
